// File: rtl/sdr_bank_monitor.sv
// Passive SDRAM command-bus monitor: tracks every bank's state and open row,
// and checks tRCD/tRAS/tRP plus command legality.
// Latency: 1 clock from command sample to err_* / bank_open / bank_row.
// Backpressure: none; purely observing, it never stalls the bus.
//
// Ports:
//   sdram_clk, sdram_resetn         clock, async active-low reset
//   sdr_cke/cs_n/ras_n/cas_n/we_n   command pins; sdr_ba bank; sdr_addr row/A10
//   clr_err                         clears err_sticky and viol_cnt
//   bank_open, bank_row             per-bank open flag and last-activated row
//   err_valid/err_code/err_bank     one-cycle violation report
//   err_sticky, viol_cnt            sticky flag and saturating count
module sdr_bank_monitor #(
  parameter int NUM_BANKS = 4,
  parameter int BA_W      = 2,
  parameter int ROW_W     = 13,
  parameter int T_RCD     = 3,
  parameter int T_RAS     = 6,
  parameter int T_RP      = 3
) (
  input  logic                       sdram_clk,
  input  logic                       sdram_resetn,
  input  logic                       sdr_cke,
  input  logic                       sdr_cs_n,
  input  logic                       sdr_ras_n,
  input  logic                       sdr_cas_n,
  input  logic                       sdr_we_n,
  input  logic [BA_W-1:0]            sdr_ba,
  input  logic [ROW_W-1:0]           sdr_addr,
  input  logic                       clr_err,
  output logic [NUM_BANKS-1:0]       bank_open,
  output logic [NUM_BANKS*ROW_W-1:0] bank_row,
  output logic                       err_valid,
  output logic [2:0]                 err_code,
  output logic [BA_W-1:0]            err_bank,
  output logic                       err_sticky,
  output logic [15:0]                viol_cnt
);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ACTIVATING  = 2'd1;
  localparam logic [1:0] ST_ACTIVE      = 2'd2;
  localparam logic [1:0] ST_PRECHARGING = 2'd3;

  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_NOP   = 4'b0111;

  localparam int T_MAX = (T_RCD > T_RAS) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                         : ((T_RAS > T_RP) ? T_RAS : T_RP);
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
  // A single-cycle timer skips the transient state entirely.
  localparam logic [1:0] ACT_NEXT = (T_RCD == 1) ? ST_ACTIVE : ST_ACTIVATING;
  localparam logic [1:0] PRE_NEXT = (T_RP == 1)  ? ST_IDLE   : ST_PRECHARGING;

  logic [1:0]       state   [NUM_BANKS];
  logic [CNT_W-1:0] rcd_cnt [NUM_BANKS];
  logic [CNT_W-1:0] ras_cnt [NUM_BANKS];
  logic [CNT_W-1:0] rp_cnt  [NUM_BANKS];

  logic [3:0] cmd;
  logic       is_act, is_rw, is_pre, is_refmrs, a10;
  logic       viol;
  logic [2:0] viol_code;
  logic [BA_W-1:0] viol_bank;

  // Deselect or clock-disable masks the command; timers keep running.
  assign cmd = (!sdr_cke || sdr_cs_n) ? CMD_NOP
                                      : {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
  assign is_act    = (cmd == CMD_ACT);
  assign is_rw     = (cmd == CMD_READ) || (cmd == CMD_WRITE);
  assign is_pre    = (cmd == CMD_PRE);
  assign is_refmrs = (cmd == CMD_REF) || (cmd == CMD_MRS);
  assign a10       = sdr_addr[10];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_open[b] = (state[b] == ST_ACTIVATING) || (state[b] == ST_ACTIVE);
    end
  end

  // Violation detection. Multi-bank scans run high-to-low so the
  // lowest-numbered offender is the one left standing.
  always_comb begin
    viol      = 1'b0;
    viol_code = 3'd0;
    viol_bank = sdr_ba;
    if (is_act) begin
      if (bank_open[sdr_ba]) begin
        viol = 1'b1; viol_code = 3'd1;
      end else if (state[sdr_ba] == ST_PRECHARGING) begin
        viol = 1'b1; viol_code = 3'd5;
      end
    end else if (is_rw) begin
      if (state[sdr_ba] == ST_ACTIVATING) begin
        viol = 1'b1; viol_code = 3'd3;
      end else if (state[sdr_ba] != ST_ACTIVE) begin
        viol = 1'b1; viol_code = 3'd2;
      end
    end else if (is_pre) begin
      if (!a10) begin
        if (bank_open[sdr_ba] && ras_cnt[sdr_ba] != '0) begin
          viol = 1'b1; viol_code = 3'd4;
        end
      end else begin
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
          if (bank_open[b] && ras_cnt[b] != '0) begin
            viol = 1'b1; viol_code = 3'd4; viol_bank = BA_W'(b);
          end
        end
      end
    end else if (is_refmrs) begin
      for (int b = NUM_BANKS - 1; b >= 0; b--) begin
        if (state[b] != ST_IDLE) begin
          viol = 1'b1; viol_code = 3'd6; viol_bank = BA_W'(b);
        end
      end
    end
  end

  // Per-bank FSMs and timers. The timed transitions fire on the edge where
  // the counter steps from 1 to 0, so the bank is ACTIVE (or IDLE) exactly
  // T_RCD (or T_RP) edges after the opening command.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state[b]   <= ST_IDLE;
        rcd_cnt[b] <= '0;
        ras_cnt[b] <= '0;
        rp_cnt[b]  <= '0;
      end
      bank_row <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rcd_cnt[b] != '0) rcd_cnt[b] <= rcd_cnt[b] - ONE;
        if (ras_cnt[b] != '0) ras_cnt[b] <= ras_cnt[b] - ONE;
        if (rp_cnt[b]  != '0) rp_cnt[b]  <= rp_cnt[b]  - ONE;
        if (state[b] == ST_ACTIVATING && rcd_cnt[b] <= ONE) state[b] <= ST_ACTIVE;
        if (state[b] == ST_PRECHARGING && rp_cnt[b] <= ONE) state[b] <= ST_IDLE;

        // The FSM follows the command even when it was a violation.
        if (is_act && sdr_ba == BA_W'(b)) begin
          state[b]   <= ACT_NEXT;
          rcd_cnt[b] <= RCD_LOAD;
          ras_cnt[b] <= RAS_LOAD;
          bank_row[b*ROW_W +: ROW_W] <= sdr_addr;
        end else if (bank_open[b] && is_pre && (a10 || sdr_ba == BA_W'(b))) begin
          state[b]  <= PRE_NEXT;
          rp_cnt[b] <= RP_LOAD;
        end else if (state[b] == ST_ACTIVE && is_rw && a10 && sdr_ba == BA_W'(b)) begin
          state[b]  <= PRE_NEXT;
          rp_cnt[b] <= RP_LOAD;
        end
      end
    end
  end

  // Error reporting. A violation in the same cycle as clr_err still counts.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      err_valid  <= 1'b0;
      err_code   <= 3'd0;
      err_bank   <= '0;
      err_sticky <= 1'b0;
      viol_cnt   <= 16'd0;
    end else begin
      err_valid <= viol;
      err_code  <= viol ? viol_code : 3'd0;
      err_bank  <= viol ? viol_bank : '0;
      if (viol) begin
        err_sticky <= 1'b1;
        if (clr_err)                viol_cnt <= 16'd1;
        else if (viol_cnt != 16'hFFFF) viol_cnt <= viol_cnt + 16'd1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        viol_cnt   <= 16'd0;
      end
    end
  end

endmodule
